mpm_port_initiator: RTL and testbench
=====================================

// Module: mpm_port_initiator
// PURPOSE
//   Initiator side of the multi-ported LVT memory port interface (addr/en/d/q per port).
//   Accepts per-port client requests over valid/ready and drives registered memory port signals.
//   Captures read data after the memory's fixed read latency and returns it per port, in order,
//   through a credit-protected response FIFO.
//   Sits between client engines and the LVT memory instance, one initiator lane per memory port.
// PARAMETERS
//   WIDTH       32   data width; must match the memory
//   DEPTH       512  memory words; address width is $clog2(DEPTH)
//   PORTS       8    number of memory ports / client lanes
//   RD_LATENCY  1    cycles from mem_addr driven to mem_q valid (>=1)
//   RSP_DEPTH   4    per-port response FIFO entries (power of 2, >=2)
// PORTS
//   clk        in   1                   clock
//   rst        in   1                   synchronous active-high reset
//   req_valid  in   1 [PORTS]           client request valid
//   req_ready  out  1 [PORTS]           request accepted when valid&ready
//   req_write  in   1 [PORTS]           1=write, 0=read
//   req_addr   in   $clog2(DEPTH) [PORTS]  request address
//   req_data   in   WIDTH [PORTS]       write data (ignored on read)
//   rsp_valid  out  1 [PORTS]           read data valid
//   rsp_ready  in   1 [PORTS]           client consumes response
//   rsp_data   out  WIDTH [PORTS]       read data
//   mem_addr   out  $clog2(DEPTH) [PORTS]  to memory addr
//   mem_en     out  1 [PORTS]           to memory en (write enable)
//   mem_d      out  WIDTH [PORTS]       to memory d
//   mem_q      in   WIDTH [PORTS]       from memory q
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): mem_en=0, mem_addr=0, mem_d=0, rsp_valid=0, read pipeline valid bits
//     cleared, FIFOs empty, credits=RSP_DEPTH. In-flight reads are dropped, never returned.
//   - Credits per port: credits = RSP_DEPTH - (reads in flight + FIFO occupancy). Decrement on read accept,
//     increment on rsp pop; accept and pop in the same cycle leave it unchanged. Never below 0 or above RSP_DEPTH.
//   - req_ready[p] = !rst & (req_write[p] | credits[p]>0) & !conflict_stall[p]. It is combinational from req_*.
//   - Accept at edge t: mem_addr/mem_d/mem_en are registered and drive the memory during cycle t+1.
//     mem_en=1 only for an accepted write. Otherwise mem_en=0, mem_addr holds its last value, and mem_d=0.
//   - A read accepted at t pushes mem_q into the FIFO at edge t+1+RD_LATENCY. The pipeline is a
//     RD_LATENCY-deep shift of valid bits. The push always has space (credit guarantee).
//   - Response FIFO is first-word-fall-through. rsp_valid=!empty. Pop on rsp_valid&rsp_ready.
//     A push into an empty FIFO is visible on rsp_valid the next cycle. Simultaneous push+pop when full is legal.
//   - Each port issues at most one op per cycle. Ordering is preserved per port and not guaranteed across ports.
//   - No forwarding: a same-cycle write and read to one address on different ports returns the memory's
//     native (old) data.
// CONFIGURATION
//   MPM_CONFLICT_STALL_EN defined: conflict_stall[p]=1 if any port k<p has req_valid&req_write with
//     req_addr[k]==req_addr[p] and req_write[p]. The lowest-index writer wins. Losers hold and retry the next cycle.
//   Undefined: conflict_stall=0. Same-address multi-port writes are issued; the stored value is the memory's
//     (LVT last-writer) behaviour.
// STRUCTURE
//   mpm_pkg: localparam-derived ADDR_W, typedef addr_t, typedef word_t, typedef credit_t ($clog2(RSP_DEPTH)+1 bits).
//   Sub-module mpm_rsp_fifo (WIDTH, RSP_DEPTH; push/pop/empty/full/count), one instance per port via generate.
//   Conflict detect and credit logic live inline in mpm_port_initiator.
// TESTING
//   1. Reset then idle: all mem_en=0, rsp_valid=0, req_ready=1 for every port. Hold rst 3 cycles mid-read:
//      no rsp_valid is ever produced.
//   2. Port0 writes 0xDEADBEEF@0x10, then port3 reads 0x10: mem_en[0]=1 one cycle after accept.
//      rsp_data[3]=0xDEADBEEF, rsp_valid[3] at accept+2+RD_LATENCY.
//   3. Port1 reads 6 addresses back-to-back with rsp_ready=0 (RSP_DEPTH=4): exactly 4 accepted, req_ready[1]=0 after.
//      Raising rsp_ready drains them in order and re-admits the rest.
//   4. Ports 2 and 5 both write @0x20 in the same cycle (0x1111/0x5555), MPM_CONFLICT_STALL_EN defined:
//      port2 accepted, req_ready[5]=0 that cycle, accepted the next. A later read returns 0x5555.
//   5. Same as 4 without the macro: both accepted in one cycle, two mem_en asserted together.
//   6. All PORTS read distinct addresses every cycle with rsp_ready=1 for 200 cycles:
//      full throughput of 1 rsp/port/cycle, data matches the scoreboard.

Source files
------------

// File: rtl/mpm_pkg.sv
// rtl/mpm_pkg.sv - shared defaults, types and width helpers for the multi-ported memory initiator
package mpm_pkg;

    localparam int MPM_WIDTH      = 32;
    localparam int MPM_DEPTH      = 512;
    localparam int MPM_PORTS      = 8;
    localparam int MPM_RD_LATENCY = 1;
    localparam int MPM_RSP_DEPTH  = 4;

    localparam int ADDR_W   = $clog2(MPM_DEPTH);
    localparam int CREDIT_W = $clog2(MPM_RSP_DEPTH) + 1;

    typedef logic [ADDR_W-1:0]    addr_t;
    typedef logic [MPM_WIDTH-1:0] word_t;
    typedef logic [CREDIT_W-1:0]  credit_t;

    // Credit counters must hold the value RSP_DEPTH itself, hence one bit beyond the pointer width
    function automatic int mpm_credit_w(input int rsp_depth);
        return $clog2(rsp_depth) + 1;
    endfunction

endpackage

// File: rtl/mpm_rsp_fifo.sv
// rtl/mpm_rsp_fifo.sv - per-port first-word-fall-through response FIFO
module mpm_rsp_fifo
    import mpm_pkg::*;
#(
    parameter int WIDTH     = MPM_WIDTH,
    parameter int RSP_DEPTH = MPM_RSP_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(RSP_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [WIDTH-1:0] store_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_ok;

    // Head entry is always presented, so data is valid in the same cycle empty_o drops
    assign pop_data_o = store_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (PTR_W+1)'(RSP_DEPTH));
    assign count_o    = count_q;
    assign pop_ok     = pop_i & ~empty_o;

    // Pointer and occupancy next-state; a push and pop together leave the count unchanged
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/mpm_port_initiator.sv
// rtl/mpm_port_initiator.sv - per-port initiator lanes driving an LVT multi-ported memory; optional MPM_CONFLICT_STALL_EN
module mpm_port_initiator
    import mpm_pkg::*;
#(
    parameter int WIDTH      = MPM_WIDTH,
    parameter int DEPTH      = MPM_DEPTH,
    parameter int PORTS      = MPM_PORTS,
    parameter int RD_LATENCY = MPM_RD_LATENCY,
    parameter int RSP_DEPTH  = MPM_RSP_DEPTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [PORTS-1:0]                     req_valid_i,
    output logic [PORTS-1:0]                     req_ready_o,
    input  logic [PORTS-1:0]                     req_write_i,
    input  logic [PORTS-1:0][$clog2(DEPTH)-1:0]  req_addr_i,
    input  logic [PORTS-1:0][WIDTH-1:0]          req_data_i,
    output logic [PORTS-1:0]                     rsp_valid_o,
    input  logic [PORTS-1:0]                     rsp_ready_i,
    output logic [PORTS-1:0][WIDTH-1:0]          rsp_data_o,
    output logic [PORTS-1:0][$clog2(DEPTH)-1:0]  mem_addr_o,
    output logic [PORTS-1:0]                     mem_en_o,
    output logic [PORTS-1:0][WIDTH-1:0]          mem_d_o,
    input  logic [PORTS-1:0][WIDTH-1:0]          mem_q_i
);

    localparam int LANE_ADDR_W = $clog2(DEPTH);
    localparam int LANE_CRED_W = mpm_credit_w(RSP_DEPTH);
    localparam int CNT_W       = $clog2(RSP_DEPTH) + 1;

    logic [PORTS-1:0]                   conflict_stall;
    logic [PORTS-1:0]                   acc_wr;
    logic [PORTS-1:0]                   acc_rd;
    logic [PORTS-1:0]                   rsp_pop;
    logic [PORTS-1:0]                   fifo_push;
    logic [PORTS-1:0]                   fifo_empty;
    logic [PORTS-1:0]                   fifo_full;
    logic [PORTS-1:0][CNT_W-1:0]        fifo_count;
    logic [LANE_CRED_W-1:0]             credit [PORTS];

    // Bit 0 marks the cycle the address is on the bus, bits 1..RD_LATENCY track the memory latency
    logic [RD_LATENCY:0]                rd_pipe_q [PORTS];
    logic [RD_LATENCY:0]                rd_pipe_d [PORTS];

    logic [PORTS-1:0]                   mem_en_q, mem_en_d;
    logic [PORTS-1:0][LANE_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [PORTS-1:0][WIDTH-1:0]        mem_d_q, mem_d_d;

    assign mem_en_o    = mem_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_d_o     = mem_d_q;
    assign rsp_valid_o = ~fifo_empty;

    // Same-address write arbitration: the lowest-index writer proceeds, higher writers retry
    always_comb begin
        conflict_stall = '0;
`ifdef MPM_CONFLICT_STALL_EN
        for (int p = 1; p < PORTS; p++) begin
            for (int k = 0; k < p; k++) begin
                if (req_valid_i[k] && req_write_i[k] && req_write_i[p] &&
                    (req_addr_i[k] == req_addr_i[p])) begin
                    conflict_stall[p] = 1'b1;
                end
            end
        end
`endif
    end

    // Credits: every slot is owned by either an in-flight read or a queued response
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            credit[p] = LANE_CRED_W'(RSP_DEPTH - $countones(rd_pipe_q[p]) - int'(fifo_count[p]));
        end
    end

    // Handshake: writes never need credit, reads need a free response slot
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            req_ready_o[p] = !rst_i && (req_write_i[p] || (credit[p] != '0)) && !conflict_stall[p];
            acc_wr[p]      = req_valid_i[p] && req_ready_o[p] && req_write_i[p];
            acc_rd[p]      = req_valid_i[p] && req_ready_o[p] && !req_write_i[p];
            rsp_pop[p]     = rsp_valid_o[p] && rsp_ready_i[p];
        end
    end

    // Memory port next-state: address holds when idle so the memory sees a stable bus
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            mem_en_d[p]   = acc_wr[p];
            mem_addr_d[p] = (acc_wr[p] || acc_rd[p]) ? req_addr_i[p] : mem_addr_q[p];
            mem_d_d[p]    = acc_wr[p] ? req_data_i[p] : '0;
        end
    end

    // Read-latency tracking; the oldest bit lines up with valid mem_q data
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            rd_pipe_d[p] = {rd_pipe_q[p][RD_LATENCY-1:0], acc_rd[p]};
            // Credit accounting keeps this gate transparent; it only guards the oldest entry
            fifo_push[p] = rd_pipe_q[p][RD_LATENCY] && (!fifo_full[p] || rsp_pop[p]);
        end
    end

    // Registered memory port and read pipeline; reset drops any read still in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_q   <= '0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            for (int p = 0; p < PORTS; p++) begin
                rd_pipe_q[p] <= '0;
            end
        end else begin
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_d_q    <= mem_d_d;
            for (int p = 0; p < PORTS; p++) begin
                rd_pipe_q[p] <= rd_pipe_d[p];
            end
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_lane
        mpm_rsp_fifo #(
            .WIDTH     (WIDTH),
            .RSP_DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .push_i      (fifo_push[g]),
            .push_data_i (mem_q_i[g]),
            .pop_i       (rsp_pop[g]),
            .pop_data_o  (rsp_data_o[g]),
            .empty_o     (fifo_empty[g]),
            .full_o      (fifo_full[g]),
            .count_o     (fifo_count[g])
        );
    end

endmodule

// File: tb/tb_mpm_port_initiator.sv
// tb/tb_mpm_port_initiator.sv - randomized self-checking bench with a transaction-level reference model
module tb_mpm_port_initiator;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 512;
    localparam int PORTS     = 8;
    localparam int RD_L      = 1;
    localparam int RSP_DEPTH = 4;
    localparam int ADDR_W    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PORTS-1:0]             req_valid, req_ready, req_write;
    logic [PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [PORTS-1:0][WIDTH-1:0]  req_data;
    logic [PORTS-1:0]             rsp_valid, rsp_ready;
    logic [PORTS-1:0][WIDTH-1:0]  rsp_data;
    logic [PORTS-1:0][ADDR_W-1:0] mem_addr;
    logic [PORTS-1:0]             mem_en;
    logic [PORTS-1:0][WIDTH-1:0]  mem_d;
    logic [PORTS-1:0][WIDTH-1:0]  mem_q;

    mpm_port_initiator #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .RD_LATENCY(RD_L), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .mem_addr_o(mem_addr), .mem_en_o(mem_en), .mem_d_o(mem_d), .mem_q_i(mem_q)
    );

    // Memory emulation: sampled reads see pre-edge contents, highest port wins a same-cycle write
    logic [WIDTH-1:0]            mem_arr [DEPTH] = '{default: '0};
    logic [PORTS-1:0][WIDTH-1:0] q_pipe  [RD_L];
    always @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            q_pipe[0][p] <= mem_arr[mem_addr[p]];
            if (mem_en[p]) mem_arr[mem_addr[p]] <= mem_d[p];
        end
        for (int s = 1; s < RD_L; s++) q_pipe[s] <= q_pipe[s-1];
    end
    assign mem_q = q_pipe[RD_L-1];

    // Reference model: per-port queue of expected responses and the cycle each becomes visible
    typedef struct {
        logic [WIDTH-1:0] data;
        int               vis;
    } exp_rsp_t;

    exp_rsp_t                     exp_q [PORTS][$];
    logic [WIDTH-1:0]             ref_mem [DEPTH] = '{default: '0};
    logic [PORTS-1:0]             exp_en   = '0;
    logic [PORTS-1:0][ADDR_W-1:0] exp_addr = '0;
    logic [PORTS-1:0][WIDTH-1:0]  exp_d    = '0;
    logic [PORTS-1:0]             acc_m, pop_m;
    int                           pops_total   [PORTS] = '{default: 0};
    int                           accepts_total[PORTS] = '{default: 0};
    int                           cyc    = 0;
    int                           checks = 0;
    int                           errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle();
        req_valid = '0;
        req_write = '0;
    endtask

    // One clock: check all outputs against the model, update the model, advance to the next negedge
    task automatic run_cycle();
        logic [PORTS-1:0] exp_rdy;
        logic             exp_v;
        logic             stall;
        #1;
        for (int p = 0; p < PORTS; p++) begin
            stall = 1'b0;
`ifdef MPM_CONFLICT_STALL_EN
            for (int k = 0; k < p; k++)
                if (req_valid[k] && req_write[k] && req_write[p] && req_addr[k] == req_addr[p])
                    stall = 1'b1;
`endif
            exp_rdy[p] = !rst && (req_write[p] || exp_q[p].size() < RSP_DEPTH) && !stall;
            check_eq($sformatf("req_ready[%0d]", p), 64'(req_ready[p]), 64'(exp_rdy[p]));
            exp_v = (exp_q[p].size() > 0) && (exp_q[p][0].vis <= cyc);
            check_eq($sformatf("rsp_valid[%0d]", p), 64'(rsp_valid[p]), 64'(exp_v));
            if (exp_v)
                check_eq($sformatf("rsp_data[%0d]", p), 64'(rsp_data[p]), 64'(exp_q[p][0].data));
            check_eq($sformatf("mem_en[%0d]", p), 64'(mem_en[p]), 64'(exp_en[p]));
            if (exp_en[p])
                check_eq($sformatf("mem_addr[%0d]", p), 64'(mem_addr[p]), 64'(exp_addr[p]));
            check_eq($sformatf("mem_d[%0d]", p), 64'(mem_d[p]), 64'(exp_d[p]));
            acc_m[p] = req_valid[p] && exp_rdy[p];
            pop_m[p] = exp_v && rsp_ready[p];
        end
        // Reads accepted this cycle observe only writes accepted in earlier cycles
        for (int p = 0; p < PORTS; p++)
            if (acc_m[p] && !req_write[p])
                exp_q[p].push_back('{data: ref_mem[req_addr[p]], vis: cyc + 2 + RD_L});
        for (int p = 0; p < PORTS; p++)
            if (acc_m[p] && req_write[p]) ref_mem[req_addr[p]] = req_data[p];
        for (int p = 0; p < PORTS; p++) begin
            if (pop_m[p]) begin
                exp_q[p].delete(0);
                pops_total[p]++;
            end
            if (acc_m[p]) accepts_total[p]++;
            exp_en[p] = acc_m[p] && req_write[p];
            if (exp_en[p]) exp_addr[p] = req_addr[p];
            exp_d[p] = exp_en[p] ? req_data[p] : '0;
            if (rst) exp_q[p].delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        idle();
        rsp_ready = '1;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    int  n, a, idx, pops_before, acc_before, sum;
    logic seen_v;

    initial begin
        rst = 1'b1;
        idle();
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = '0;
        @(negedge clk);

        // 1. Reset, idle state, then a reset that lands on reads in flight
        for (int i = 0; i < 3; i++) run_cycle();
        rst = 1'b0;
        #1;
        check_eq("t1_ready_all", 64'(req_ready), 64'({PORTS{1'b1}}));
        check_eq("t1_mem_en", 64'(mem_en), 64'(0));
        check_eq("t1_rsp_valid", 64'(rsp_valid), 64'(0));
        for (int p = 0; p < PORTS; p++)
            check_eq($sformatf("t1_mem_addr[%0d]", p), 64'(mem_addr[p]), 64'(0));
        run_cycle();
        req_valid = '1;
        for (int p = 0; p < PORTS; p++) req_addr[p] = ADDR_W'(p * 3);
        run_cycle();
        idle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle();
        rst = 1'b0;
        seen_v = 1'b0;
        rsp_ready = '1;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            seen_v |= |rsp_valid;
        end
        check_eq("t1_no_rsp_after_reset", 64'(seen_v), 64'(0));

        // 2. Write on port 0, read back on port 3
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 9'h010; req_data[0] = 32'hDEADBEEF;
        run_cycle();
        check_eq("t2_wr_accept", 64'(acc_m[0]), 64'(1));
        idle();
        check_eq("t2_mem_en0", 64'(mem_en[0]), 64'(1));
        check_eq("t2_mem_addr0", 64'(mem_addr[0]), 64'h10);
        req_valid[3] = 1'b1; req_addr[3] = 9'h010;
        a = cyc;
        run_cycle();
        idle();
        n = 0;
        while (!rsp_valid[3] && n < 10) begin run_cycle(); n++; end
        check_eq("t2_latency", 64'(cyc - a), 64'(2 + RD_L));
        check_eq("t2_rsp_data3", 64'(rsp_data[3]), 64'hDEADBEEF);
        drain(4);

        // 3. Credit back-pressure on port 1
        rsp_ready[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid[1] = 1'b1; req_write[1] = 1'b1;
            req_addr[1]  = ADDR_W'(9'h041 + i * 8); req_data[1] = $urandom();
            run_cycle();
        end
        idle();
        idx = 0;
        pops_before = pops_total[1];
        for (int i = 0; i < 6; i++) begin
            req_valid[1] = 1'b1; req_addr[1] = ADDR_W'(9'h041 + idx * 8);
            run_cycle();
            if (acc_m[1]) idx++;
        end
        check_eq("t3_accepted", 64'(idx), 64'(RSP_DEPTH));
        #1;
        check_eq("t3_ready_low", 64'(req_ready[1]), 64'(0));
        rsp_ready[1] = 1'b1;
        n = 0;
        while (idx < 6 && n < 40) begin
            req_addr[1] = ADDR_W'(9'h041 + idx * 8);
            run_cycle();
            if (acc_m[1]) idx++;
            n++;
        end
        check_eq("t3_all_accepted", 64'(idx), 64'(6));
        drain(8);
        check_eq("t3_pops", 64'(pops_total[1] - pops_before), 64'(6));

        // 4/5. Two ports write the same address in one cycle
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 9'h020; req_data[2] = 32'h1111;
        req_valid[5] = 1'b1; req_write[5] = 1'b1; req_addr[5] = 9'h020; req_data[5] = 32'h5555;
        #1;
`ifdef MPM_CONFLICT_STALL_EN
        check_eq("t4_ready2", 64'(req_ready[2]), 64'(1));
        check_eq("t4_ready5_stalled", 64'(req_ready[5]), 64'(0));
        run_cycle();
        req_valid[2] = 1'b0; req_write[2] = 1'b0;
        run_cycle();
        check_eq("t4_port5_retry", 64'(acc_m[5]), 64'(1));
        idle();
`else
        check_eq("t5_both_ready", 64'({req_ready[5], req_ready[2]}), 64'(2'b11));
        run_cycle();
        idle();
        check_eq("t5_both_mem_en", 64'({mem_en[5], mem_en[2]}), 64'(2'b11));
`endif
        run_cycle(); run_cycle();
        req_valid[0] = 1'b1; req_addr[0] = 9'h020;
        run_cycle();
        idle();
        n = 0;
        while (!rsp_valid[0] && n < 10) begin run_cycle(); n++; end
        check_eq("t4_readback", 64'(rsp_data[0]), 64'h5555);
        drain(6);

        // 6. Every port reads every cycle for 200 cycles
        for (int p = 0; p < PORTS; p++) begin
            acc_before  += accepts_total[p];
            pops_before += pops_total[p];
        end
        acc_before = 0; pops_before = 0;
        for (int p = 0; p < PORTS; p++) begin
            acc_before  += accepts_total[p];
            pops_before += pops_total[p];
        end
        req_valid = '1; req_write = '0; rsp_ready = '1;
        for (int i = 0; i < 200; i++) begin
            for (int p = 0; p < PORTS; p++) req_addr[p] = ADDR_W'((i * PORTS + p) % DEPTH);
            run_cycle();
        end
        sum = 0;
        for (int p = 0; p < PORTS; p++) sum += accepts_total[p];
        check_eq("t6_accepts", 64'(sum - acc_before), 64'(PORTS * 200));
        sum = 0;
        for (int p = 0; p < PORTS; p++) sum += pops_total[p];
        check_eq("t6_pops_in_window", 64'(sum - pops_before), 64'(PORTS * (200 - 2 - RD_L)));
        drain(8);

        // 7. Random mixed traffic with occasional resets; writes are port-partitioned by address
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int p = 0; p < PORTS; p++) begin
                req_valid[p] = ($urandom_range(0, 3) != 0);
                req_write[p] = ($urandom_range(0, 2) == 0);
                req_addr[p]  = req_write[p] ? {6'($urandom()), 3'(p)} : ADDR_W'($urandom());
                req_data[p]  = $urandom();
                rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            run_cycle();
        end
        rst = 1'b0;
        drain(10);
        check_eq("t7_drained", 64'(rsp_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
